// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: VGA timing generator plus two-stage cell-grid renderer.
// Optional cursor overlay is compiled in with `define CURSOR_OVERLAY_EN.
module vga_grid_renderer #(
   parameter int          WIDTH      = 12,
   parameter int          HSIZE      = 800,
   parameter int          HFP        = 856,
   parameter int          HSP        = 976,
   parameter int          HMAX       = 1040,
   parameter int          VSIZE      = 600,
   parameter int          VFP        = 637,
   parameter int          VSP        = 643,
   parameter int          VMAX       = 666,
   parameter int          HSPP       = 1,
   parameter int          VSPP       = 1,
   parameter int          P_PARAM_N  = 16,
   parameter int          P_PARAM_M  = 16,
   parameter int          CELL_LOG2  = 5,
   parameter logic [23:0] ALIVE_RGB  = 24'hFFFFFF,
   parameter logic [23:0] DEAD_RGB   = 24'h0000FF,
   parameter logic [23:0] BORDER_RGB = 24'h000000,
`ifdef CURSOR_OVERLAY_EN
   parameter logic [23:0] CURSOR_RGB = 24'hFF0000,
`endif
   parameter logic [23:0] BG_RGB     = 24'h000000
) (
   input  logic                             clk,
   input  logic                             rst_n,
`ifdef CURSOR_OVERLAY_EN
   input  logic [$clog2(P_PARAM_N)-1:0]     cursor_col,
   input  logic [$clog2(P_PARAM_M)-1:0]     cursor_row,
   input  logic                             cursor_on,
`endif
   input  logic [P_PARAM_N*P_PARAM_M-1:0]   status,
   output logic [WIDTH-1:0]                 hdata,
   output logic [WIDTH-1:0]                 vdata,
   output logic                             hsync,
   output logic                             vsync,
   output logic                             data_enable,
   output logic [7:0]                       video_red,
   output logic [7:0]                       video_green,
   output logic [7:0]                       video_blue,
   output logic                             frame_start
);

   localparam int CELLS = P_PARAM_N * P_PARAM_M;
   localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [WIDTH-1:0] H_LAST = WIDTH'(HMAX - 1);
   localparam logic [WIDTH-1:0] V_LAST = WIDTH'(VMAX - 1);
   localparam logic [WIDTH-1:0] H_VIS  = WIDTH'(HSIZE);
   localparam logic [WIDTH-1:0] V_VIS  = WIDTH'(VSIZE);
   localparam logic [WIDTH-1:0] H_FP   = WIDTH'(HFP);
   localparam logic [WIDTH-1:0] H_SP   = WIDTH'(HSP);
   localparam logic [WIDTH-1:0] V_FP   = WIDTH'(VFP);
   localparam logic [WIDTH-1:0] V_SP   = WIDTH'(VSP);
   localparam logic [WIDTH-1:0] N_W    = WIDTH'(P_PARAM_N);
   localparam logic [WIDTH-1:0] M_W    = WIDTH'(P_PARAM_M);
   localparam logic             HS_ON  = 1'(HSPP);
   localparam logic             VS_ON  = 1'(VSPP);

   logic [CELLS-1:0]     snap_q;
   logic                 line_end;
   logic                 frame_end;
   logic [WIDTH-1:0]     col_c;
   logic [WIDTH-1:0]     row_c;
   logic [CELL_LOG2-1:0] xo;
   logic [CELL_LOG2-1:0] yo;
   logic                 in_grid_c;
   logic                 brd_c;
   logic                 vis_c;
   logic                 hs_c;
   logic                 vs_c;
   logic [IW-1:0]        idx_c;

   logic                 s1_vis;
   logic                 s1_in;
   logic                 s1_brd;
   logic                 s1_bit;
   logic                 s1_hs;
   logic                 s1_vs;
   logic [23:0]          rgb_nxt;
   logic [23:0]          rgb_q;

   assign line_end    = (hdata == H_LAST);
   assign frame_end   = line_end && (vdata == V_LAST);
   assign frame_start = (hdata == '0) && (vdata == '0);

   assign col_c = hdata >> CELL_LOG2;
   assign row_c = vdata >> CELL_LOG2;
   assign xo    = hdata[CELL_LOG2-1:0];
   assign yo    = vdata[CELL_LOG2-1:0];

   assign vis_c     = (hdata < H_VIS) && (vdata < V_VIS);
   assign in_grid_c = vis_c && (col_c < N_W) && (row_c < M_W);
   assign brd_c     = (xo == '0) || (yo == '0);
   assign hs_c      = (hdata >= H_FP && hdata < H_SP) ? HS_ON : ~HS_ON;
   assign vs_c      = (vdata >= V_FP && vdata < V_SP) ? VS_ON : ~VS_ON;

   // Lookup index only formed inside the grid; clipped pixels read bit 0.
   assign idx_c = in_grid_c ? IW'(row_c * N_W + col_c) : '0;

`ifdef CURSOR_OVERLAY_EN
   localparam logic [CELL_LOG2-1:0] OFF1 = CELL_LOG2'(1);
   localparam logic [CELL_LOG2-1:0] OFFM = '1;

   logic [$clog2(P_PARAM_N)-1:0] cur_col_q;
   logic [$clog2(P_PARAM_M)-1:0] cur_row_q;
   logic                         cur_on_q;
   logic                         cur_c;
   logic                         s1_cur;

   assign cur_c = cur_on_q
               && (col_c == WIDTH'(cur_col_q))
               && (row_c == WIDTH'(cur_row_q))
               && (xo == OFF1 || xo == OFFM
                   || yo == OFF1 || yo == OFFM);

   // Cursor inputs are captured with the status frame snapshot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_col_q <= '0;
         cur_row_q <= '0;
         cur_on_q  <= 1'b0;
         s1_cur    <= 1'b0;
      end else begin
         if (frame_end) begin
            cur_col_q <= cursor_col;
            cur_row_q <= cursor_row;
            cur_on_q  <= cursor_on;
         end
         s1_cur <= cur_c;
      end
   end
`endif

   // Raster counters: horizontal wraps each line, vertical each frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hdata <= '0;
         vdata <= '0;
      end else if (line_end) begin
         hdata <= '0;
         vdata <= (vdata == V_LAST) ? '0 : vdata + 1'b1;
      end else begin
         hdata <= hdata + 1'b1;
      end
   end

   // Frame snapshot so mid-frame status updates never tear the picture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q <= '0;
      end else if (frame_end) begin
         snap_q <= status;
      end
   end

   // Stage 1: cell classification and snapshot lookup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vis <= 1'b0;
         s1_in  <= 1'b0;
         s1_brd <= 1'b0;
         s1_bit <= 1'b0;
         s1_hs  <= ~HS_ON;
         s1_vs  <= ~VS_ON;
      end else begin
         s1_vis <= vis_c;
         s1_in  <= in_grid_c;
         s1_brd <= brd_c;
         s1_bit <= snap_q[idx_c];
         s1_hs  <= hs_c;
         s1_vs  <= vs_c;
      end
   end

   // Colour priority: blanking, background, border, cursor, cell state.
   always_comb begin
      rgb_nxt = '0;
      if (!s1_vis) begin
         rgb_nxt = '0;
      end else if (!s1_in) begin
         rgb_nxt = BG_RGB;
      end else if (s1_brd) begin
         rgb_nxt = BORDER_RGB;
`ifdef CURSOR_OVERLAY_EN
      end else if (s1_cur) begin
         rgb_nxt = CURSOR_RGB;
`endif
      end else if (s1_bit) begin
         rgb_nxt = ALIVE_RGB;
      end else begin
         rgb_nxt = DEAD_RGB;
      end
   end

   // Stage 2: colour plus sync/enable, all aligned two cycles behind counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q       <= '0;
         hsync       <= ~HS_ON;
         vsync       <= ~VS_ON;
         data_enable <= 1'b0;
      end else begin
         rgb_q       <= rgb_nxt;
         hsync       <= s1_hs;
         vsync       <= s1_vs;
         data_enable <= s1_vis;
      end
   end

   assign video_red   = rgb_q[23:16];
   assign video_green = rgb_q[15:8];
   assign video_blue  = rgb_q[7:0];

endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: directed plus random checks of the grid renderer
// against a raster-position model, using a small timing configuration.
module tb_vga_grid_renderer;

   localparam int W    = 12;
   localparam int HS   = 24;
   localparam int HF   = 26;
   localparam int HP   = 30;
   localparam int HM   = 34;
   localparam int VS   = 20;
   localparam int VF   = 22;
   localparam int VP   = 24;
   localparam int VM   = 26;
   localparam int N    = 4;
   localparam int M    = 6;
   localparam int CL   = 2;
   localparam int CELL = 1 << CL;
   localparam int NB   = N * M;
   localparam int FL   = HM * VM;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [NB-1:0] status = '0;
   logic [W-1:0]  hdata;
   logic [W-1:0]  vdata;
   logic          hsync;
   logic          vsync;
   logic          data_enable;
   logic [7:0]    video_red;
   logic [7:0]    video_green;
   logic [7:0]    video_blue;
   logic          frame_start;

   int            n_assert = 0;
   int            n_fail = 0;
   int            p = 0;
   logic [NB-1:0] snaps[$];

   vga_grid_renderer #(
      .WIDTH(W), .HSIZE(HS), .HFP(HF), .HSP(HP), .HMAX(HM),
      .VSIZE(VS), .VFP(VF), .VSP(VP), .VMAX(VM),
      .P_PARAM_N(N), .P_PARAM_M(M), .CELL_LOG2(CL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .status(status),
      .hdata(hdata),
      .vdata(vdata),
      .hsync(hsync),
      .vsync(vsync),
      .data_enable(data_enable),
      .video_red(video_red),
      .video_green(video_green),
      .video_blue(video_blue),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s p=%0d observed=%0h expected=%0h",
                tag, p, obs, exp);
      end
   endtask

   function automatic logic [23:0] ref_rgb(input int x, input int y,
                                           input logic [NB-1:0] s);
      int col;
      int row;
      if (x >= HS || y >= VS) return 24'h000000;
      col = x / CELL;
      row = y / CELL;
      if (col >= N || row >= M) return 24'h000000;
      if (x % CELL == 0 || y % CELL == 0) return 24'h000000;
      return s[row * N + col] ? 24'hFFFFFF : 24'h0000FF;
   endfunction

   function automatic logic [23:0] rgb_out();
      return {video_red, video_green, video_blue};
   endfunction

   task automatic check_now();
      int q;
      int x;
      int y;
      chk("hdata", 32'(hdata), p % HM);
      chk("vdata", 32'(vdata), (p / HM) % VM);
      chk("frame_start", 32'(frame_start), 32'(p % FL == 0));
      if (p < 2) begin
         chk("rgb_pre", 32'(rgb_out()), 0);
         chk("de_pre", 32'(data_enable), 0);
         chk("hs_pre", 32'(hsync), 0);
         chk("vs_pre", 32'(vsync), 0);
      end else begin
         q = p - 2;
         x = q % HM;
         y = (q / HM) % VM;
         chk("rgb", 32'(rgb_out()), 32'(ref_rgb(x, y, snaps[q / FL])));
         chk("de", 32'(data_enable), 32'(x < HS && y < VS));
         chk("hsync", 32'(hsync), 32'(x >= HF && x < HP));
         chk("vsync", 32'(vsync), 32'(y >= VF && y < VP));
      end
   endtask

   task automatic step();
      if (p % FL == FL - 1) snaps.push_back(status);
      @(posedge clk);
      #1;
      p++;
      check_now();
   endtask

   task automatic goto_pix(input int x, input int y);
      bit hit = 1'b0;
      for (int n = 0; n < FL + 4 && !hit; n++) begin
         step();
         hit = (p >= 2) && ((p - 2) % HM == x)
            && (((p - 2) / HM) % VM == y);
      end
      chk("goto_reach", 32'(hit), 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_h"}, 32'(hdata), 0);
      chk({tag, "_v"}, 32'(vdata), 0);
      chk({tag, "_rgb"}, 32'(rgb_out()), 0);
      chk({tag, "_de"}, 32'(data_enable), 0);
      chk({tag, "_hs"}, 32'(hsync), 0);
      chk({tag, "_vs"}, 32'(vsync), 0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      p = 0;
      snaps.delete();
      snaps.push_back('0);
      #1;
      check_now();
   endtask

   initial begin
      int cnt;
      bit seen;
      bit prev;

      // power-on reset
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("por");
      release_reset();
      step();
      chk("count1", 32'(hdata), 1);
      step();
      chk("count2", 32'(hdata), 2);

      // frame 0 renders all dead
      goto_pix(6, 6);
      chk("f0_dead", 32'(rgb_out()), 32'h0000FF);
      status = NB'(1) << 5;

      // frame 1: one live cell at row 1 col 1
      goto_pix(1, 1);
      chk("dead_1_1", 32'(rgb_out()), 32'h0000FF);
      goto_pix(20, 2);
      chk("bg_rgb", 32'(rgb_out()), 0);
      chk("bg_de", 32'(data_enable), 1);
      goto_pix(25, 2);
      chk("blank_rgb", 32'(rgb_out()), 0);
      chk("blank_de", 32'(data_enable), 0);
      goto_pix(4, 6);
      chk("border", 32'(rgb_out()), 0);
      goto_pix(6, 6);
      chk("alive", 32'(rgb_out()), 32'hFFFFFF);

      // mid-frame status change must not show until next frame
      goto_pix(0, 12);
      status[0]  = 1'b1;
      status[16] = 1'b1;
      goto_pix(1, 17);
      chk("tear_hold", 32'(rgb_out()), 32'h0000FF);
      goto_pix(1, 1);
      chk("tear_next0", 32'(rgb_out()), 32'hFFFFFF);
      goto_pix(1, 17);
      chk("tear_next16", 32'(rgb_out()), 32'hFFFFFF);

      // hsync rising position and width, line period
      seen = 1'b0;
      prev = hsync;
      for (int n = 0; n < 2 * HM && !seen; n++) begin
         step();
         seen = hsync && !prev;
         prev = hsync;
      end
      chk("hs_rise_seen", 32'(seen), 1);
      chk("hs_rise_pos", 32'(hdata), (HF + 2) % HM);
      cnt = 0;
      while (hsync && cnt < HM) begin
         step();
         cnt++;
      end
      chk("hs_width", cnt, HP - HF);
      seen = 1'b0;
      prev = hsync;
      for (int n = 0; n < 2 * HM && !seen; n++) begin
         step();
         cnt++;
         seen = hsync && !prev;
         prev = hsync;
      end
      chk("line_period", cnt, HM);

      // frame_start period and vsync width
      seen = 1'b0;
      for (int n = 0; n < FL + 2 && !seen; n++) begin
         step();
         seen = frame_start;
      end
      chk("fs_seen", 32'(seen), 1);
      cnt = 0;
      seen = 1'b0;
      for (int n = 0; n < FL + 2 && !seen; n++) begin
         step();
         cnt++;
         seen = frame_start;
      end
      chk("fs_period", cnt, FL);
      cnt = 0;
      for (int n = 0; n < FL; n++) begin
         step();
         if (vsync) cnt++;
      end
      chk("vs_width", cnt, (VP - VF) * HM);

      // random status, redrawn each frame and sometimes mid-frame
      for (int i = 0; i < 2 * FL; i++) begin
         if (p % FL == 0 || $urandom_range(63) == 0)
            status = NB'($urandom());
         step();
      end

      // reset in the middle of a frame
      cnt = 0;
      while (!(p % HM == 10 && (p / HM) % VM == 12) && cnt < FL) begin
         step();
         cnt++;
      end
      chk("mid_pos", 32'(hdata), 10);
      status = '1;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outs("mid");
      repeat (5) begin
         @(negedge clk);
         chk_reset_outs("hold");
      end
      release_reset();
      step();
      step();
      goto_pix(6, 6);
      chk("post_rst_dead", 32'(rgb_out()), 32'h0000FF);
      goto_pix(6, 6);
      chk("post_rst_alive", 32'(rgb_out()), 32'hFFFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_grid_renderer.md
Name: vga_grid_renderer

Overview:
- Parametrised successor to the Game-of-Life VGA block: timing generator plus pipelined cell-grid renderer.
- Grid size (P_PARAM_N columns × P_PARAM_M rows), cell size and colours are parameters.
- Latches the cell status vector once per frame, so the display never tears while the life engine updates mid-frame.
- Sync and data-enable are delayed to line up with the pixel pipeline.
- Sits between the life engine (status source) and the video output pins.

Parameters:
- WIDTH, 12, bit width of hdata/vdata counters
- HSIZE, 800, visible pixels per line
- HFP, 856, hsync pulse start (HSIZE + front porch)
- HSP, 976, hsync pulse end (HFP + sync width)
- HMAX, 1040, total pixels per line
- VSIZE, 600, visible lines
- VFP, 637, vsync pulse start
- VSP, 643, vsync pulse end
- VMAX, 666, total lines per frame
- HSPP, 1, hsync active polarity
- VSPP, 1, vsync active polarity
- P_PARAM_N, 16, grid columns
- P_PARAM_M, 16, grid rows
- CELL_LOG2, 5, log2 of cell edge in pixels (32 px)
- ALIVE_RGB, 24'hFFFFFF, colour of a live cell
- DEAD_RGB, 24'h0000FF, colour of a dead cell
- BORDER_RGB, 24'h000000, colour of the cell grid lines
- BG_RGB, 24'h000000, colour of visible area outside the grid

Ports:
- clk  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- status  in  P_PARAM_N*P_PARAM_M  cell states; bit index = row*P_PARAM_N+col; 1 = alive
- hdata  out  WIDTH  raw horizontal counter (pipeline stage 0)
- vdata  out  WIDTH  raw vertical counter (pipeline stage 0)
- hsync  out  1  horizontal sync, aligned with the RGB outputs
- vsync  out  1  vertical sync, aligned with the RGB outputs
- data_enable  out  1  visible-area flag, aligned with the RGB outputs
- video_red / video_green / video_blue  out  8 each  pixel colour
- frame_start  out  1  high for exactly the cycles where hdata==0 and vdata==0

Behaviour:
- Reset (async assert, sync release):
  - hdata = vdata = 0
  - pipeline sync regs = !HSPP / !VSPP; data_enable = 0
  - RGB = 0
  - snapshot register = 0, so the first frame after reset renders every cell dead
- Counters:
  - hdata wraps HMAX-1 → 0.
  - vdata increments only when hdata==HMAX-1 and wraps VMAX-1 → 0.
- Snapshot: status is copied into the internal frame register on the cycle hdata==HMAX-1 and vdata==VMAX-1. It holds for the whole following frame. status changes at any other time have no visible effect until the next frame.
- frame_start is decoded from the counter registers. Its period is HMAX*VMAX cycles, and it is also high in the first cycle after reset release.
- Stage 1 registers:
  - col = hdata>>CELL_LOG2, row = vdata>>CELL_LOG2
  - in_grid = hdata<HSIZE && vdata<VSIZE && col<P_PARAM_N && row<P_PARAM_M
  - edge = hdata[CELL_LOG2-1:0]==0 || vdata[CELL_LOG2-1:0]==0
  - visible flag, raw sync levels
  - looked-up snapshot bit
- Stage 2 registers the colour with this priority:
  - not visible → 0
  - visible && !in_grid → BG_RGB
  - edge → BORDER_RGB
  - bit=1 → ALIVE_RGB, else DEAD_RGB
- Latency: hsync, vsync, data_enable and RGB present at the outputs reflect the counter value from exactly 2 cycles earlier. All four are mutually aligned.
- Grid clipping: a grid larger than the visible area is clipped silently. The lookup index is never formed for out-of-grid coordinates, so there is no out-of-range access.
- Reset mid-frame clears everything immediately. Timing restarts at (0,0) with frame_start high.

Optional Feature:
- Macro: CURSOR_OVERLAY_EN
- When defined:
  - Adds ports cursor_col in $clog2(P_PARAM_N), cursor_row in $clog2(P_PARAM_M), cursor_on in 1.
  - Adds parameter CURSOR_RGB, default 24'hFF0000.
  - Cursor inputs are snapshotted together with status.
  - In the cursor cell with cursor_on=1, pixels with x-offset or y-offset ∈ {1, 2^CELL_LOG2-1} take CURSOR_RGB. This sits below BORDER_RGB and above the alive/dead colours in the priority order.
- When undefined: the ports and logic are absent and the output is identical to the rules above.

Test Plan:
- Reset: assert rst_n=0 for 5 cycles at hdata=400, vdata=300 → hdata=vdata=0, RGB=0, data_enable=0, hsync=0, vsync=0 immediately. After release, hdata counts 0,1,2 and frame_start=1 on the first cycle.
- Timing, defaults:
  - hsync high for 120 cycles, rising 2 cycles after hdata reaches 856
  - line period 1040 cycles
  - vsync high for 6 lines starting at line 637
  - frame_start period 692640 cycles
- Render: status bit 17 = 1, others 0, after one snapshot →
  - pixel (40,40) = FFFFFF
  - (32,40) = 000000 (border)
  - (5,5) = 0000FF
  - (600,100) = 000000 with data_enable=1
  - (850,10) = 0 with data_enable=0
- Tearing: toggle status bit 0 from 0→1 at vdata=300 → pixel (5,5) stays 0000FF for the rest of the frame and becomes FFFFFF in the next frame.
- Latency: compare each output against a model of counters delayed by 2 → zero mismatches over 2 full frames with random status at every frame_start.
- CURSOR_OVERLAY_EN: cursor_col=2, cursor_row=3, cursor_on=1 →
  - pixel (65,100) = FF0000
  - (64,100) = 000000
  - (80,110) = cell colour
  - cursor_on=0 restores the normal colour next frame
